// File: rtl/aes_inv_iter.sv
// Iterative AES inverse cipher: one decryption round per enabled clock, using the
// encryption round-key array in reverse order, valid/ready on both sides.

module inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   localparam logic [7:0] TBL [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   assign y_o = TBL[a_i];

endmodule

module aes_inv_iter #(
   parameter int NR = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [127:0]       ciphertext_i,
   input  logic [NR:0][127:0] round_key_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [127:0]       plaintext_o,
   output logic               busy_o
);

   // Handshake: a block moves on a rising edge where valid and ready are both high;
   // a source holds its data stable while valid is high and ready is low.

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]   fsm_q, fsm_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] state_q, state_d;
   logic [127:0] pt_q, pt_d;
   logic         valid_q, valid_d;

   logic [127:0] sub_w, add_w, mix_w;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a, x2, x4, x8;
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a     = col[31-8*i -: 8];
         x2    = xtime(a);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // InvShiftRows is pure wiring: row r of column c reads column (c - r) mod 4.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int DST = r + 4*c;
         localparam int SRC = r + 4*((c - r + 4) % 4);
         inv_sbox u_inv_sbox (
            .a_i (state_q[127-8*SRC -: 8]),
            .y_o (sub_w[127-8*DST -: 8])
         );
      end
      assign mix_w[127-32*c -: 32] = inv_mix_col(add_w[127-32*c -: 32]);
   end

   assign add_w = sub_w ^ round_key_i[rnd_q];

   always_comb begin
      fsm_d   = fsm_q;
      rnd_d   = rnd_q;
      state_d = state_q;
      pt_d    = pt_q;
      valid_d = valid_q;
      case (fsm_q)
         S_IDLE: begin
            if (valid_i) begin
               state_d = ciphertext_i ^ round_key_i[NR];
               rnd_d   = 4'(NR - 1);
               fsm_d   = S_ROUND;
            end
         end
         S_ROUND: begin
            if (en) begin
               if (rnd_q != 4'd0) begin
                  state_d = mix_w;
                  rnd_d   = rnd_q - 4'd1;
               end else begin
                  state_d = add_w;
                  pt_d    = add_w;
                  valid_d = 1'b1;
                  fsm_d   = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (ready_i) begin
               valid_d = 1'b0;
               fsm_d   = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= S_IDLE;
         rnd_q   <= 4'd0;
         state_q <= 128'd0;
         pt_q    <= 128'd0;
         valid_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         rnd_q   <= rnd_d;
         state_q <= state_d;
         pt_q    <= pt_d;
         valid_q <= valid_d;
      end
   end

   assign ready_o     = (fsm_q == S_IDLE);
   assign busy_o      = (fsm_q != S_IDLE);
   assign valid_o     = valid_q;
   assign plaintext_o = pt_q;

endmodule

// File: tb/tb_aes_inv_iter.sv
// Bench for aes_inv_iter at NR=10/12/14: a forward-cipher reference model produces
// ciphertexts, a scoreboard queue holds expected plaintexts checked by a monitor.

module tb_aes_inv_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [2:0]        en, vi, ri, ro, vo, bo;
   logic [2:0][127:0] ct, pt;
   logic [10:0][127:0] rk10;
   logic [12:0][127:0] rk12;
   logic [14:0][127:0] rk14;

   aes_inv_iter #(.NR(10)) u_dut10 (
      .clk(clk), .rst(rst), .en(en[0]), .valid_i(vi[0]), .ready_o(ro[0]),
      .ciphertext_i(ct[0]), .round_key_i(rk10), .valid_o(vo[0]), .ready_i(ri[0]),
      .plaintext_o(pt[0]), .busy_o(bo[0]));
   aes_inv_iter #(.NR(12)) u_dut12 (
      .clk(clk), .rst(rst), .en(en[1]), .valid_i(vi[1]), .ready_o(ro[1]),
      .ciphertext_i(ct[1]), .round_key_i(rk12), .valid_o(vo[1]), .ready_i(ri[1]),
      .plaintext_o(pt[1]), .busy_o(bo[1]));
   aes_inv_iter #(.NR(14)) u_dut14 (
      .clk(clk), .rst(rst), .en(en[2]), .valid_i(vi[2]), .ready_o(ro[2]),
      .ciphertext_i(ct[2]), .round_key_i(rk14), .valid_o(vo[2]), .ready_i(ri[2]),
      .plaintext_o(pt[2]), .busy_o(bo[2]));

   // ---------------- reference model: forward AES ----------------
   logic [7:0]   sb [256];
   logic [127:0] rk_tab [3][15];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand(input int k, input logic [255:0] key);
      int nr, nk;
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      nr = 10 + 2*k;
      nk = nr - 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) rk_tab[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = 0; r <= nr; r++) begin
         if (k == 0) rk10[r] = rk_tab[0][r];
         else if (k == 1) rk12[r] = rk_tab[1][r];
         else rk14[r] = rk_tab[2][r];
      end
   endtask

   function automatic logic [127:0] mixcols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
         o[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                              a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                              a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                              gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
      end
      return o;
   endfunction

   function automatic logic [127:0] encrypt(input int k, input logic [127:0] p);
      logic [127:0] s, u;
      int nr, r, c;
      nr = 10 + 2*k;
      s  = p ^ rk_tab[k][0];
      for (int rd = 1; rd <= nr; rd++) begin
         for (int i = 0; i < 16; i++) begin
            r = i % 4;
            c = i / 4;
            u[127-8*i -: 8] = sb[s[127-8*(r + 4*((c + r) % 4)) -: 8]];
         end
         if (rd != nr) u = mixcols(u);
         s = u ^ rk_tab[k][rd];
      end
      return s;
   endfunction

   // ---------------- scoreboard and checking ----------------
   logic [127:0] exp_q [$];
   int           lat_q [$];
   int           dut_q [$];
   int           n_chk = 0, n_fail = 0, n_xfer = 0;
   int           cyc = 0;
   int           acc_cyc [3];
   logic [2:0]   in_flight = 3'b000;
   logic [2:0]   vo_prev = 3'b000;
   bit           mon_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("ready_o[%0d]", k), 128'(ro[k]), 128'(!in_flight[k]));
            if (vo[k] && !vo_prev[k]) begin
               if (lat_q.size() == 0) chk_int($sformatf("unexpected valid_o[%0d]", k), 1, 0);
               else chk_int($sformatf("latency[%0d]", k), cyc - acc_cyc[k], lat_q[0]);
            end
            if (vo[k] && ri[k]) begin
               if (exp_q.size() == 0) begin
                  chk_int($sformatf("extra transfer[%0d]", k), 1, 0);
               end else begin
                  chk_int("transfer source", k, dut_q.pop_front());
                  chk($sformatf("plaintext[%0d]", k), pt[k], exp_q.pop_front());
                  void'(lat_q.pop_front());
               end
               in_flight[k] = 1'b0;
               n_xfer++;
            end
            vo_prev[k] = vo[k];
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input int k, input logic [127:0] c, input logic [127:0] e,
                       input int lat, input bit push);
      int n;
      n = 0;
      if (push) begin
         exp_q.push_back(e);
         lat_q.push_back(lat);
         dut_q.push_back(k);
      end
      ct[k] = c;
      vi[k] = 1'b1;
      @(negedge clk);
      while (!ro[k] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk_int("accept timeout", 128'(ro[k]) == 1 ? 1 : 0, 1);
      @(posedge clk);
      #1;
      acc_cyc[k]   = cyc;
      in_flight[k] = 1'b1;
      vi[k]        = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      while (in_flight[k] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk_int("drain timeout", int'(in_flight[k]), 0);
      @(posedge clk);
      #1;
   endtask

   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] p, c, b2b_p [3];
      logic [255:0] key;
      int pat [64];
      int ones, len, n, x0;

      rst = 1'b1; en = 3'b111; vi = 3'b000; ri = 3'b111; ct = '0;
      rk10 = '0; rk12 = '0; rk14 = '0;
      build_sbox();
      expand(0, KEY128); expand(1, KEY192); expand(2, KEY256);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset ready_o[%0d]", k), 128'(ro[k]), 128'd1);
         chk($sformatf("reset valid_o[%0d]", k), 128'(vo[k]), 128'd0);
         chk($sformatf("reset busy_o[%0d]", k), 128'(bo[k]), 128'd0);
         chk($sformatf("reset plaintext_o[%0d]", k), pt[k], 128'd0);
      end
      @(posedge clk); #1;

      // FIPS-197 known-answer decrypts for all three key sizes
      send(0, CT_C1, PT_FIPS, 10, 1); wait_idle(0);
      send(1, CT_C2, PT_FIPS, 12, 1); wait_idle(1);
      send(2, CT_C3, PT_FIPS, 14, 1); wait_idle(2);

      // random keys and blocks, ciphertext made by the forward model
      for (int k = 0; k < 3; k++) begin
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         expand(k, key);
         for (int i = 0; i < 3; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            send(k, encrypt(k, p), p, 10 + 2*k, 1);
            wait_idle(k);
         end
      end
      expand(0, KEY128); expand(1, KEY192); expand(2, KEY256);

      // random en stalls during ROUND
      for (int it = 0; it < 2; it++) begin
         ones = 0; len = 0;
         while (ones < 10) begin
            pat[len] = (len >= 40) ? 1 : int'($urandom_range(0, 1));
            if (pat[len] != 0) ones++;
            len++;
         end
         send(0, CT_C1, PT_FIPS, len, 1);
         for (int j = 0; j < len; j++) begin
            en[0] = (pat[j] != 0);
            @(posedge clk); #1;
         end
         en[0] = 1'b1;
         wait_idle(0);
      end

      // backpressure: ready_i low for several cycles after valid_o rises
      ri[0] = 1'b0;
      send(0, CT_C1, PT_FIPS, 10, 1);
      n = 0;
      @(negedge clk);
      while (!vo[0] && n < 100) begin @(negedge clk); n++; end
      for (int i = 0; i < 6; i++) begin
         chk("stall valid_o", 128'(vo[0]), 128'd1);
         chk("stall plaintext_o", pt[0], PT_FIPS);
         chk("stall ready_o", 128'(ro[0]), 128'd0);
         if (i < 5) @(negedge clk);
      end
      @(posedge clk); #1 ri[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("valid_o after transfer", 128'(vo[0]), 128'd0);
      chk("plaintext_o holds after transfer", pt[0], PT_FIPS);
      wait_idle(0);

      // back-to-back with valid_i held while busy
      x0 = n_xfer;
      b2b_p[0] = PT_FIPS;
      b2b_p[1] = {$urandom, $urandom, $urandom, $urandom};
      b2b_p[2] = {$urandom, $urandom, $urandom, $urandom};
      send(0, CT_C1, b2b_p[0], 10, 1);
      send(0, encrypt(0, b2b_p[1]), b2b_p[1], 10, 1);
      send(0, encrypt(0, b2b_p[2]), b2b_p[2], 10, 1);
      wait_idle(0);
      chk_int("back-to-back transfer count", n_xfer - x0, 3);

      // reset in the middle of a decrypt
      send(0, CT_C1, PT_FIPS, 10, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("busy_o mid-decrypt", 128'(bo[0]), 128'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      in_flight[0] = 1'b0;
      @(negedge clk);
      chk("post-reset valid_o", 128'(vo[0]), 128'd0);
      chk("post-reset busy_o", 128'(bo[0]), 128'd0);
      chk("post-reset ready_o", 128'(ro[0]), 128'd1);
      chk("post-reset plaintext_o", pt[0], 128'd0);
      repeat (20) @(negedge clk);
      @(posedge clk); #1;
      send(0, CT_C1, PT_FIPS, 10, 1); wait_idle(0);

      // reset coinciding with valid_i: block must not be taken
      ct[0] = CT_C1; vi[0] = 1'b1; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; vi[0] = 1'b0;
      @(negedge clk);
      chk("rst+valid busy_o", 128'(bo[0]), 128'd0);
      repeat (15) @(negedge clk);
      chk_int("scoreboard drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_inv_iter.md
Name: aes_inv_iter

Overview:
- Iterative AES inverse cipher (FIPS-197 §5.3), one round per clock. It is the decrypt counterpart of the pipelined `aes` encryptor.
- It consumes the same encryption round-key array as `aes`, produced by the shared key expansion, and applies the keys in reverse order.
- Sits on the receive path: ciphertext arrives over a valid/ready input, plaintext leaves over a valid/ready output with backpressure.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); drives round_key_i depth and counter terminal value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  round-advance enable; low freezes the round datapath and counter.
- valid_i  input  1  ciphertext_i valid.
- ready_o  output  1  block can accept ciphertext.
- ciphertext_i  input  128  input block; byte 0 at [127:120], column-major per FIPS-197.
- round_key_i  input  128 x (NR+1)  encryption round keys [NR:0]; must stay stable from acceptance until output transfer.
- valid_o  output  1  plaintext_o valid.
- ready_i  input  1  downstream accepts plaintext_o.
- plaintext_o  output  128  decrypted block, same byte order.
- busy_o  output  1  high in ROUND and DONE.

Behaviour:
- Reset: synchronous on rising edge with rst=1; overrides all other inputs.
  - FSM returns to IDLE, round counter goes to 0, state register goes to 0.
  - valid_o=0, plaintext_o=0, busy_o=0; ready_o=1 from the first cycle after reset.
  - Reset mid-ROUND or in DONE discards the block with no output.
- FSM states: IDLE, ROUND, DONE.
- ready_o = (fsm==IDLE), combinational from the registered state; en does not affect it.
- IDLE:
  - On valid_i && ready_o: state <= ciphertext_i ^ round_key_i[NR], rnd <= NR-1, go to ROUND.
  - en is ignored for acceptance.
- ROUND, when en=1:
  - t = InvSubBytes(InvShiftRows(state)) ^ round_key_i[rnd].
  - If rnd != 0: state <= InvMixColumns(t), rnd <= rnd-1.
  - If rnd == 0: state <= t, go to DONE.
- ROUND, when en=0: state, rnd and fsm hold.
- DONE:
  - valid_o=1 and plaintext_o = state, both registered.
  - On ready_i: go to IDLE, valid_o <= 0; plaintext_o holds its last value.
  - en is ignored in DONE.
  - plaintext_o must not change while valid_o=1 && !ready_i.
- Latency, en held high: acceptance at edge T, valid_o high after edge T+NR (10/12/14 cycles). Each en=0 cycle spent in ROUND adds exactly 1 cycle.
- Throughput: at most one block per NR+2 cycles, because there is no accept in DONE.
- rnd is 4 bits wide; NR-1 must fit in it, which holds for all legal NR.
- rnd never underflows: the rnd==0 step always exits to DONE.
- Arithmetic:
  - InvMixColumns uses GF(2^8) with polynomial 0x11B, coefficient matrix {0e,0b,0d,09}.
  - xtime is implemented by shift plus conditional XOR with 0x1B.
- Inverse S-box: 16 combinational instances of the codebase's inv_sbox table; no multi-cycle lookup.
- Simultaneous events:
  - valid_i while busy: not accepted (ready_o=0). The source must hold its block.
  - ready_i low in DONE: holds indefinitely.
  - rst together with valid_i: reset wins; the block is not accepted.
- Legal NR values are 10, 12 and 14; the bench covers all three.

Test Plan:
- AES-128 (NR=10), FIPS-197 C.1:
  - Key expansion of 000102030405060708090a0b0c0d0e0f; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with ready_i=1 and en=1.
  - Required: plaintext_o=00112233445566778899aabbccddeeff with valid_o high exactly 10 cycles after acceptance.
- AES-192 (NR=12) and AES-256 (NR=14), FIPS-197 C.2/C.3 keys:
  - Ciphertexts dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089.
  - Required: both decrypt to 00112233445566778899aabbccddeeff, at latencies 12 and 14 respectively.
- Random en stall:
  - C.1 vector with en random 50% during ROUND.
  - Required: correct plaintext; latency = 10 + number of en=0 cycles in ROUND.
- Backpressure:
  - Hold ready_i=0 for 5 cycles after valid_o rises.
  - Required: valid_o and plaintext_o stable for 5 cycles; ready_o=0 throughout; transfer on the first ready_i=1 cycle; ready_o=1 the next cycle.
- Back-to-back with busy input:
  - Hold valid_i=1 with 3 blocks (the C.1 ciphertext plus 2 encryptions produced by `aes`).
  - Required: the next block is accepted only in IDLE, outputs arrive in order, all match, and there are no duplicate or dropped transfers.
- Reset mid-operation:
  - Assert rst at round 5 of a decrypt.
  - Required: next cycle valid_o=0, busy_o=0, ready_o=1, plaintext_o=0. A following C.1 decrypt completes correctly.
